// File: rtl/uart_tx.sv
// UART transmitter: start bit, D_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit is held for prescale clk cycles. TX_OUT and busy come straight from flops.
module uart_tx #(
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] P_DATA,
   input  logic               DATA_VALID,
   input  logic               PAR_EN,
   input  logic               PAR_TYPE,
   input  logic [5:0]         prescale,
   output logic               TX_OUT,
   output logic               busy
);

   // state  | meaning
   // IDLE   | line high, waiting for DATA_VALID
   // START  | start bit (low)
   // DATA   | data bit data_l[bit_idx], LSB first
   // PARITY | parity bit (only when parity enabled at acceptance)
   // STOP   | stop bit (high); requests still dropped here
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int IW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(D_WIDTH - 1);

   state_t               state_q, state_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [D_WIDTH-1:0]   data_l_q, data_l_d;
   logic                 par_en_l_q, par_en_l_d;
   logic                 parity_l_q, parity_l_d;
   logic [5:0]           pre_l_q, pre_l_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 bit_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         data_l_q   <= '0;
         par_en_l_q <= 1'b0;
         parity_l_q <= 1'b0;
         pre_l_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         data_l_q   <= data_l_d;
         par_en_l_q <= par_en_l_d;
         parity_l_q <= parity_l_d;
         pre_l_q    <= pre_l_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   assign bit_end = (cnt_q == (pre_l_q - 6'd1));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      data_l_d   = data_l_q;
      par_en_l_d = par_en_l_q;
      parity_l_d = parity_l_q;
      pre_l_d    = pre_l_q;
      if (state_q == IDLE) begin
         if (DATA_VALID) begin
            data_l_d   = P_DATA;
            par_en_l_d = PAR_EN;
            parity_l_d = (^P_DATA) ^ PAR_TYPE;
            pre_l_d    = (prescale == 6'd0) ? 6'd1 : prescale;
            cnt_d      = '0;
            idx_d      = '0;
            state_d    = START;
         end
      end else if (bit_end) begin
         cnt_d = '0;
         case (state_q)
            START:   state_d = DATA;
            DATA: begin
               if (idx_q == LAST_IDX) begin
                  state_d = par_en_l_q ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            PARITY:  state_d = STOP;
            STOP:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end else begin
         cnt_d = cnt_q + 6'd1;
      end
   end

   // Outputs are decoded from the next state so the flops present the new bit on the same edge.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b1;
      case (state_d)
         IDLE:    busy_d = 1'b0;
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_l_d[idx_d];
         PARITY:  tx_d = parity_l_d;
         STOP:    tx_d = 1'b1;
         default: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized frames against a bit-list model.
module tb_uart_tx;

   logic       clk;
   logic       rst;
   logic [7:0] p_data;
   logic       data_valid;
   logic       par_en;
   logic       par_type;
   logic [5:0] prescale;
   logic       tx_out;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   uart_tx #(.D_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (p_data),
      .DATA_VALID (data_valid),
      .PAR_EN     (par_en),
      .PAR_TYPE   (par_type),
      .prescale   (prescale),
      .TX_OUT     (tx_out),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected line level for every clk cycle of the frame, built from the frame definition.
   function automatic void build_wave(input logic [7:0] d, input logic pen, input logic ptype,
                                      input logic [5:0] pre, output int wave[$]);
      int bits[$];
      int p;
      p = (pre == 0) ? 1 : int'(pre);
      bits.push_back(0);
      for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
      if (pen) bits.push_back(int'((^d) ^ ptype));
      bits.push_back(1);
      wave = {};
      foreach (bits[b]) for (int c = 0; c < p; c++) wave.push_back(bits[b]);
   endfunction

   // Called at a negedge. mode 0: plain; 1: config changes mid-frame; 2: dropped requests.
   task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                            input logic ptype, input logic [5:0] pre, input int mode);
      int wave[$];
      int len;
      build_wave(d, pen, ptype, pre, wave);
      len = wave.size();
      p_data = d; par_en = pen; par_type = ptype; prescale = pre;
      data_valid = 1'b1;
      for (int k = 0; k <= len; k++) begin
         @(negedge clk);
         if (k < len) begin
            chk({tag, "_tx"}, 32'(tx_out), 32'(wave[k]));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
         end else begin
            chk({tag, "_end_busy"}, 32'(busy), 32'd0);
            chk({tag, "_end_tx"}, 32'(tx_out), 32'd1);
         end
         data_valid = 1'b0;
         if (mode == 1 && k == 1) begin
            p_data = ~d; par_type = ~ptype; par_en = ~pen;
            prescale = pre + 6'd3;
         end
         if (mode == 2 && (k == len / 2 || k == len - 1)) begin
            data_valid = 1'b1;
            p_data = 8'h55;
         end
      end
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
         chk({tag, "_idle_tx"}, 32'(tx_out), 32'd1);
      end
   endtask

   task automatic reset_abort();
      p_data = 8'h00; par_en = 1'b0; par_type = 1'b0; prescale = 6'd4;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("rst_pre_tx", 32'(tx_out), 32'd0);
      chk("rst_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_tx", 32'(tx_out), 32'd1);
      chk("rst_async_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_cycles(50, "rst_after");
   endtask

   initial begin
      rst = 1'b1;
      data_valid = 1'b0;
      p_data = '0; par_en = 1'b0; par_type = 1'b0; prescale = 6'd1;
      repeat (2) @(negedge clk);
      chk("reset_tx", 32'(tx_out), 32'd1);
      chk("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      idle_cycles(2, "post_reset");

      run_frame("nopar_a5", 8'hA5, 1'b0, 1'b0, 6'd8, 0);
      idle_cycles(1, "g1");
      run_frame("even_83", 8'h83, 1'b1, 1'b0, 6'd4, 0);
      idle_cycles(1, "g2");
      run_frame("odd_83_chg", 8'h83, 1'b1, 1'b1, 6'd4, 1);
      idle_cycles(1, "g3");
      run_frame("drop_55", 8'h3C, 1'b1, 1'b0, 6'd3, 2);
      run_frame("b2b", 8'h96, 1'b0, 1'b1, 6'd2, 0);
      idle_cycles(1, "g4");
      run_frame("pre0_ff", 8'hFF, 1'b0, 1'b0, 6'd0, 0);
      idle_cycles(1, "g5");
      run_frame("pre1_ff", 8'hFF, 1'b0, 1'b0, 6'd1, 2);
      idle_cycles(1, "g6");

      reset_abort();

      for (int n = 0; n < 20; n++) begin
         logic [7:0] d;
         logic       pen, pt;
         logic [5:0] pre;
         int         mode;
         d    = 8'($urandom);
         pen  = 1'($urandom);
         pt   = 1'($urandom);
         pre  = 6'($urandom_range(0, 5));
         mode = int'($urandom_range(0, 2));
         run_frame("rand", d, pen, pt, pre, mode);
         if (mode == 2) data_valid = 1'b0;
         idle_cycles(int'($urandom_range(0, 2)), "rand_gap");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the low-power multi-clock system, driving the serial line that the UART receiver samples. It accepts a parallel word on a single-cycle valid strobe and serializes it as a frame: start bit, D_WIDTH data bits LSB first, optional parity bit, one stop bit. Each bit is held for `prescale` clk cycles, so it shares the receiver's prescale configuration semantics. Frame format is configured through the system register file (PAR_EN, PAR_TYPE, prescale).

Parameters:
D_WIDTH, 8, data word width in bits.

Ports:
clk  input  1  system/UART clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
P_DATA  input  D_WIDTH  parallel word to transmit.
DATA_VALID  input  1  one-cycle request; accepted only when busy=0.
PAR_EN  input  1  1 = parity bit inserted between data and stop.
PAR_TYPE  input  1  0 = even parity, 1 = odd parity.
prescale  input  6  clk cycles per serial bit; 0 is treated as 1.
TX_OUT  output  1  serial line; idles high; registered output.
busy  output  1  high while a frame is in progress; registered output.

Behaviour:
- Reset (async, rst=1): TX_OUT=1, busy=0, FSM=IDLE, all counters and shadow registers cleared. Reset asserted mid-frame aborts the frame immediately. TX_OUT returns high asynchronously.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - On a rising edge with DATA_VALID=1, latch P_DATA, PAR_EN, PAR_TYPE and prescale (0→1) into shadow registers.
  - Compute the parity bit from the latched data: even = XOR of all data bits; odd = inverted XOR.
  - Go to START, clear the bit-cycle counter and the bit index.
- Config input changes after acceptance have no effect on the current frame.
- Bit timing: a 6-bit cycle counter counts 0..prescale_l-1. The state/bit advances when counter = prescale_l-1.
- START: TX_OUT=0 for prescale_l cycles, then go to DATA.
- DATA:
  - TX_OUT = data_l[bit_idx], starting with bit_idx=0 (LSB first).
  - bit_idx increments after each bit period.
  - After bit D_WIDTH-1, go to PARITY if PAR_EN_l=1, else to STOP.
- PARITY: TX_OUT = parity bit for prescale_l cycles, then go to STOP.
- STOP: TX_OUT=1 for prescale_l cycles, then go to IDLE.
- busy: 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Latency: DATA_VALID sampled at edge N → TX_OUT=0 and busy=1 from edge N+1.
  - Frame length L = (2 + D_WIDTH + PAR_EN_l) × prescale_l cycles.
  - busy falls and the FSM is in IDLE from edge N+1+L.
- Back-to-back: DATA_VALID is ignored (dropped, no queuing) whenever busy=1, including the last stop cycle. A request in the first IDLE cycle after a frame is accepted. Minimum inter-frame gap is therefore 1 clk cycle of idle-high beyond the stop bit.
- TX_OUT and busy are driven from flops, never from combinational state decode, to keep the line glitch-free.
- prescale=1 is a legal edge case: one clk per bit.

Test Plan:
- Reset: hold rst=1 mid-frame (during DATA) → TX_OUT=1 and busy=0 immediately; after release, line stays high and no frame resumes.
- No parity: PAR_EN=0, prescale=8, P_DATA=0xA5 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; busy high for exactly 80 cycles.
- Even parity: PAR_EN=1, PAR_TYPE=0, prescale=4, P_DATA=0x83 → parity bit 1; frame 0,1,1,0,0,0,0,0,1,1,1, 44 busy cycles.
- Odd parity with config change: PAR_TYPE=1, P_DATA=0x83, prescale=4; change PAR_TYPE/prescale/P_DATA mid-frame → parity bit 0, timing unchanged, data unchanged.
- Busy drop: pulse DATA_VALID with 0x55 during an active frame and in the last stop cycle → both ignored. A pulse one cycle after busy falls → new frame starts next edge.
- prescale=0 and prescale=1, P_DATA=0xFF, PAR_EN=0 → both yield 1-cycle bits, 10-cycle frame: 0, eight 1s, 1.
